// File: rtl/contador_pkg.sv
// Shared constants, direction type and width helper for the mod-N counter chain.
package contador_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Bits needed to hold codes 0..mod-1.
  function automatic int stage_width(input int mod);
    return $clog2(mod);
  endfunction

endpackage

// File: rtl/contador_modn_estagio.sv
// One modulo-MOD counter digit with load-clamp and self-recovery from illegal codes.
module contador_modn_estagio
  import contador_pkg::*;
#(
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_d,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_zero
);

  // One extra bit so MOD == 2^W still compares correctly.
  localparam logic [W:0]   MOD_V = (W+1)'(MOD);
  localparam logic [W-1:0] MAX_V = W'(MOD - 1);

  logic [W-1:0] r_q;
  logic         w_legal;
  dir_t         w_dir;

  assign w_dir   = dir_t'(up);
  assign w_legal = {1'b0, r_q} < MOD_V;

  // Digit update: reset, clamped load, then step with wrap; an illegal code wraps like a boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= ({1'b0, load_d} < MOD_V) ? load_d : '0;
    end else if (step) begin
      if (w_dir == DIR_UP)
        r_q <= (r_q == MAX_V || !w_legal) ? '0 : r_q + 1'b1;
      else
        r_q <= (r_q == '0 || !w_legal) ? MAX_V : r_q - 1'b1;
    end
  end

  assign q       = r_q;
  assign at_max  = (r_q == MAX_V);
  assign at_zero = (r_q == '0);

endmodule

// File: rtl/contador_modn_cascata.sv
// Cascaded chain of mod-N digits with enable, direction, load, wrap pulse and terminal count.
module contador_modn_cascata
  import contador_pkg::*;
#(
  parameter int NUM_STAGES           = 2,
  parameter int MOD_LIST[NUM_STAGES] = '{10, 6},
  parameter int W                    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [NUM_STAGES*W-1:0] load_val,
  output logic [NUM_STAGES*W-1:0] cont,
  output logic                    carry,
  output logic                    tc
);

  logic [NUM_STAGES-1:0] w_step;
  logic [NUM_STAGES-1:0] w_at_max;
  logic [NUM_STAGES-1:0] w_at_zero;
  logic                  w_run;
  logic                  r_carry;

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_chk_n
    $error("contador_modn_cascata: NUM_STAGES out of range");
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (MOD_LIST[k] < 2 || stage_width(MOD_LIST[k]) > W) begin : g_chk_mod
      $error("contador_modn_cascata: MOD_LIST entry does not fit in W bits");
    end

    contador_modn_estagio #(
      .MOD (MOD_LIST[k]),
      .W   (W)
    ) u_est (
      .clk     (clk),
      .reset   (reset),
      .step    (w_step[k]),
      .up      (up),
      .load    (load),
      .load_d  (load_val[k*W +: W]),
      .q       (cont[k*W +: W]),
      .at_max  (w_at_max[k]),
      .at_zero (w_at_zero[k])
    );
  end

  // Ripple enable: a stage steps only when every lower stage sits at its boundary.
  always_comb begin
    w_step = '0;
    w_run  = en;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_step[k] = w_run;
      w_run     = w_run & (up ? w_at_max[k] : w_at_zero[k]);
    end
  end

  // Whole chain at its boundary with en high means this edge wraps.
  assign tc = w_run;

  // Wrap pulse: registered tc unless load or reset steals the edge.
  always_ff @(posedge clk) begin
    if (!reset)
      r_carry <= 1'b0;
    else
      r_carry <= tc & ~load;
  end

  assign carry = r_carry;

endmodule

// File: tb/tb_contador_modn_cascata.sv
// Directed bench: arithmetic mod-60 model compared every cycle plus literal checkpoints.
module tb_contador_modn_cascata;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] cont;
  logic       carry;
  logic       tc;

  int n_pass = 0;
  int n_tot  = 0;

  // Model: the pair is a single integer 0..59 (lo + 10*hi).
  int  m_v     = 0;
  bit  m_carry = 1'b0;
  bit  m_valid = 1'b0;

  contador_modn_cascata dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .cont     (cont),
    .carry    (carry),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int enc(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Model update from the inputs seen at the edge.
  always @(posedge clk) begin
    int hi, lo;
    if (!reset) begin
      m_v = 0; m_carry = 0; m_valid = 1;
    end else if (m_valid) begin
      m_carry = 0;
      if (load) begin
        hi = int'(load_val[7:4]); lo = int'(load_val[3:0]);
        if (hi >= 6) hi = 0;
        if (lo >= 10) lo = 0;
        m_v = hi * 10 + lo;
      end else if (en) begin
        if (up) begin
          m_carry = (m_v == 59);
          m_v = (m_v + 1) % 60;
        end else begin
          m_carry = (m_v == 0);
          m_v = (m_v + 59) % 60;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_cont", int'(cont), enc(m_v));
      check("model_carry", int'(carry), int'(m_carry));
      check("model_tc", int'(tc), int'(en && (up ? (m_v == 59) : (m_v == 0))));
    end
  end

  task automatic edge_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: reset dominates load/en
    reset = 0; en = 1; load = 1; load_val = 8'h37; up = 1;
    edge_n(2);
    check("rst_cont", int'(cont), 'h00);
    check("rst_carry", int'(carry), 0);
    reset = 1; en = 0; load = 0;
    edge_n(3);
    check("hold_cont", int'(cont), 'h00);

    // 2: count up through the full wrap
    en = 1; up = 1;
    edge_n(59);
    check("up59_cont", int'(cont), 'h59);
    check("up59_tc", int'(tc), 1);
    edge_n(1);
    check("upwrap_cont", int'(cont), 'h00);
    check("upwrap_carry", int'(carry), 1);
    edge_n(1);
    check("up01_cont", int'(cont), 'h01);
    check("up01_carry", int'(carry), 0);

    // 3: count down from zero
    load = 1; load_val = 8'h00;
    edge_n(1);
    load = 0; up = 0; en = 1;
    #1;
    check("dn_tc", int'(tc), 1);
    edge_n(1);
    check("dnwrap_cont", int'(cont), 'h59);
    check("dnwrap_carry", int'(carry), 1);
    edge_n(1);
    check("dn58_cont", int'(cont), 'h58);
    check("dn58_carry", int'(carry), 0);

    // 4: load clamp and load-over-en
    load = 1; en = 1; load_val = 8'h4C;
    edge_n(1);
    check("ld4C_cont", int'(cont), 'h40);
    check("ld4C_carry", int'(carry), 0);
    load_val = 8'h7C;
    edge_n(1);
    check("ld7C_cont", int'(cont), 'h00);
    load_val = 8'h59;
    edge_n(1);
    check("ld59_cont", int'(cont), 'h59);
    check("ld59_carry", int'(carry), 0);
    load = 0; up = 1; en = 1;
    edge_n(1);
    check("ldwrap_cont", int'(cont), 'h00);
    check("ldwrap_carry", int'(carry), 1);

    // hold with en low
    en = 0;
    edge_n(2);
    check("hold2_cont", int'(cont), 'h00);
    check("hold2_carry", int'(carry), 0);

    // 5: direction changes
    en = 1; up = 1;
    edge_n(9);
    check("d09_cont", int'(cont), 'h09);
    up = 0;
    edge_n(1);
    check("d08_cont", int'(cont), 'h08);
    up = 1;
    edge_n(1);
    check("d09b_cont", int'(cont), 'h09);
    edge_n(1);
    check("d10_cont", int'(cont), 'h10);

    // 6: reset at the wrap point swallows the pulse
    load = 1; load_val = 8'h59;
    edge_n(1);
    load = 0; en = 1; up = 1; reset = 0;
    edge_n(1);
    check("rstwrap_cont", int'(cont), 'h00);
    check("rstwrap_carry", int'(carry), 0);
    reset = 1;
    edge_n(1);
    check("rel_cont", int'(cont), 'h01);
    check("rel_carry", int'(carry), 0);

    en = 0;
    edge_n(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
